// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and index helpers for the round-robin register-write arbiter.
// Index helpers work on up to MAX_N requesters; callers size-cast to their own N.
package reg_write_arbiter_pkg;

  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  // First requester with req set, searching ptr, ptr+1, ... wrapping at n.
  // The loop runs backwards so the candidate closest to ptr is the one kept.
  function automatic logic [2:0] rr_next(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       ptr,
                                         input logic [3:0]       n);
    logic [3:0] idx;
    rr_next = ptr;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (4'(i) < n) begin
        idx = {1'b0, ptr} + 4'(i);
        if (idx >= n) idx = idx - n;
        if (req[idx[2:0]]) rr_next = idx[2:0];
      end
    end
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx,
                                              input logic [3:0] n);
    for (int i = 0; i < MAX_N; i++) begin
      onehot[i] = (4'(i) < n) && (3'(i) == idx);
    end
  endfunction

endpackage

// File: rtl/reg_en_async.sv
// WIDTH-bit storage register with load enable and asynchronous active-low clear.
module reg_en_async #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that is the sole writer of one shared enabled register.
// Handshake: a requester raises req with din stable and holds both until its one-cycle ack.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output state_e             state_dbg
);

  localparam int IW = $clog2(N);

  state_e          state_d, state_q;
  logic [IW-1:0]   sel_d, sel_q;
  logic [IW-1:0]   ptr_d, ptr_q;
  logic [N-1:0]    gnt_d, gnt_q;
  logic [N-1:0]    ack_d, ack_q;
  logic            wr_en;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          sel_d   = IW'(rr_next(MAX_N'(req), 3'(ptr_q), 4'(N)));
          gnt_d   = N'(onehot(3'(sel_d), 4'(N)));
          state_d = WRITE;
        end
      end
      WRITE: begin
        ack_d   = N'(onehot(3'(sel_q), 4'(N)));
        state_d = ACK;
      end
      ACK: begin
        // Pointer moves past the winner so a persistent requester yields next time.
        if (sel_q == IW'(N - 1)) ptr_d = '0;
        else                     ptr_d = sel_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  // Enable only in WRITE, so ack (registered in ACK) never overlaps a write.
  assign wr_en   = (state_q == WRITE);
  assign wr_data = din[sel_q*WIDTH +: WIDTH];

  reg_en_async #(.WIDTH(WIDTH)) u_shared_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (wr_en),
    .d       (wr_data),
    .q       (q)
  );

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, contention, fairness,
// withdrawal and mid-transaction reset, with an ack/q scoreboard.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int W     = N + WIDTH;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   q;
  logic               busy;
  state_e             state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  reg_write_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input int idx, input logic [WIDTH-1:0] data);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({oh, data});
  endtask

  task automatic set_lane(input int idx, input logic [WIDTH-1:0] data);
    din[idx*WIDTH +: WIDTH] = data;
  endtask

  // scoreboard and invariant monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n) begin
      total++;
      if (!$onehot0(gnt) || !$onehot0(ack)) begin
        bad++;
        $display("FAIL onehot: gnt=%b ack=%b", gnt, ack);
      end
      if (ack != '0) begin
        check("ack_not_in_write", 32'(state_dbg == WRITE), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ack_unexpected: ack=%b q=0x%0h expected none", ack, q);
        end else begin
          e = exp_q.pop_front();
          check("sb_ack", 32'(ack), 32'(e[W-1:WIDTH]));
          check("sb_q", 32'(q), 32'(e[WIDTH-1:0]));
        end
      end
    end
  end

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
    logic [N-1:0]     exp_gnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int acks;
    int last;
    int cyc;
    int req1_at;

    vecs[0] = '{idx: 2, data: 8'hA5, exp_gnt: 4'b0100};
    vecs[1] = '{idx: 0, data: 8'h3C, exp_gnt: 4'b0001};
    vecs[2] = '{idx: 1, data: 8'h00, exp_gnt: 4'b0010};
    vecs[3] = '{idx: 2, data: 8'h5B, exp_gnt: 4'b0100};
    vecs[4] = '{idx: 3, data: 8'hFF, exp_gnt: 4'b1000};

    reset_n = 1'b1;
    req     = '0;
    din     = '0;
    #2 reset_n = 1'b0;
    req = 4'b1111;

    // 1. reset holds everything at zero even with requests pending
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_q", 32'(q), 32'h00);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    req = '0;
    reset_n = 1'b1;

    // 3. full contention from ptr=0
    @(negedge clk);
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    expect_ack(0, 8'h11);
    expect_ack(1, 8'h22);
    expect_ack(2, 8'h33);
    expect_ack(3, 8'h44);
    expect_ack(0, 8'h11);
    acks = 0; last = -1; cyc = 0;
    while (acks < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        if (last >= 0) check("ack_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        acks++;
        if (acks == 5) req = '0;
      end
    end
    check("contention_acks", 32'(acks), 32'd5);
    @(negedge clk);
    check("contention_idle", 32'(busy), 32'd0);
    check("contention_q", 32'(q), 32'h11);
    check("contention_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2. table of single requests
    foreach (vecs[v]) begin
      din = 32'($urandom());
      set_lane(vecs[v].idx, vecs[v].data);
      req = vecs[v].exp_gnt;
      expect_ack(vecs[v].idx, vecs[v].data);
      @(negedge clk);
      check("vec_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
      check("vec_busy_write", 32'(busy), 32'd1);
      check("vec_ack_early", 32'(ack), 32'd0);
      @(negedge clk);
      check("vec_q", 32'(q), 32'(vecs[v].data));
      check("vec_ack", 32'(ack), 32'(vecs[v].exp_gnt));
      check("vec_busy_ack", 32'(busy), 32'd1);
      req = '0;
      @(negedge clk);
      check("vec_ack_once", 32'(ack), 32'd0);
      check("vec_gnt_idle", 32'(gnt), 32'd0);
      check("vec_busy_idle", 32'(busy), 32'd0);
    end

    // 4. fairness: req0 and req3 held, req1 raised after two services (ptr=0 here)
    din = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req = 4'b1001;
    expect_ack(0, 8'hD0);
    expect_ack(3, 8'hD3);
    expect_ack(0, 8'hD0);
    expect_ack(1, 8'hD1);
    expect_ack(3, 8'hD3);
    expect_ack(0, 8'hD0);
    acks = 0; cyc = 0; req1_at = -1;
    while (acks < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        acks++;
        if (acks == 2) req[1] = 1'b1;
        if (ack[1]) begin
          req[1] = 1'b0;
          req1_at = acks;
        end
        if (acks == 6) req = '0;
      end
    end
    check("fair_acks", 32'(acks), 32'd6);
    check("fair_req1_within_2", 32'(req1_at > 2 && req1_at <= 4), 32'd1);
    @(negedge clk);
    check("fair_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5. request withdrawn during WRITE still completes (ptr=1 here)
    din = 32'($urandom());
    set_lane(1, 8'h5A);
    req = 4'b0010;
    expect_ack(1, 8'h5A);
    @(negedge clk);
    check("wd_gnt", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    check("wd_q", 32'(q), 32'h5A);
    check("wd_ack", 32'(ack), 32'h2);
    @(negedge clk);
    check("wd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("wd_stays_idle", 32'(gnt), 32'd0);
    check("wd_q_hold", 32'(q), 32'h5A);

    // 6. reset during WRITE of 0xC3, then restart from ptr=0
    set_lane(0, 8'hC3);
    req = 4'b0001;
    @(negedge clk);
    check("rm_gnt", 32'(gnt), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rm_q_async", 32'(q), 32'h00);
    check("rm_gnt_async", 32'(gnt), 32'h0);
    check("rm_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    check("rm_q_hold", 32'(q), 32'h00);
    check("rm_ack", 32'(ack), 32'h0);
    set_lane(1, 8'h77);
    req = 4'b1010;
    reset_n = 1'b1;
    expect_ack(1, 8'h77);
    @(negedge clk);
    check("rm_first_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    check("rm_q_after", 32'(q), 32'h77);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
